// File: rtl/ledg_pio_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ledg_pio_write_arbiter
//  Purpose  : Round-robin arbiter sharing one green-LED PIO slave between
//             several status sources; holds each pattern before re-arbitrating.
//  Revision : 1.0  initial release
// ============================================================================
module ledg_pio_write_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        busy,
    output logic [2:0]                  grant_id,
    output logic [1:0]                  pio_address,
    output logic                        pio_chipselect,
    output logic                        pio_write_n,
    output logic [31:0]                 pio_writedata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam int               c_CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = (HOLD_CYCLES > 0) ? c_CNT_W'(HOLD_CYCLES - 1) : '0;
    localparam logic [2:0]       c_LAST_RST  = 3'(NUM_REQ - 1);

    state_t                 r_state;
    logic [2:0]             r_last;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [NUM_REQ-1:0]     r_ack;
    logic                   r_busy;
    logic [2:0]             r_gid;
    logic                   r_cs;
    logic                   r_wn;
    logic [31:0]            r_wd;

    logic [7:0]             w_req_pad;
    logic                   w_found;
    logic [2:0]             w_sel;
    logic [3:0]             w_sum;
    logic [DATA_W-1:0]      w_data;

    state_t                 w_state_nx;
    logic [2:0]             w_last_nx;
    logic [c_CNT_W-1:0]     w_cnt_nx;
    logic [NUM_REQ-1:0]     w_ack_nx;
    logic                   w_busy_nx;
    logic [2:0]             w_gid_nx;
    logic                   w_cs_nx;
    logic                   w_wn_nx;
    logic [31:0]            w_wd_nx;

    // Scan last+1, last+2, ... with wrap; the sum stays below 2*NUM_REQ <= 16.
    always_comb begin
        w_req_pad                = '0;
        w_req_pad[NUM_REQ-1:0]   = req;
        w_found                  = 1'b0;
        w_sel                    = '0;
        w_sum                    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum = {1'b0, r_last} + 4'(k);
            if (w_sum >= 4'(NUM_REQ)) begin
                w_sum = w_sum - 4'(NUM_REQ);
            end
            if (!w_found && w_req_pad[w_sum[2:0]]) begin
                w_found = 1'b1;
                w_sel   = w_sum[2:0];
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == 3'(i)) begin
                w_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_last_nx  = r_last;
        w_cnt_nx   = r_cnt;
        w_gid_nx   = r_gid;
        w_wd_nx    = r_wd;
        w_ack_nx   = '0;
        w_busy_nx  = 1'b0;
        w_cs_nx    = 1'b0;
        w_wn_nx    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nx              = S_WRITE;
                    w_last_nx               = w_sel;
                    w_gid_nx                = w_sel;
                    w_wd_nx                 = '0;
                    w_wd_nx[DATA_W-1:0]     = w_data;
                    w_ack_nx                = NUM_REQ'(1) << w_sel;
                    w_busy_nx               = 1'b1;
                    w_cs_nx                 = 1'b1;
                    w_wn_nx                 = 1'b0;
                end
            end
            S_WRITE: begin
                if (HOLD_CYCLES == 0) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_state_nx = S_HOLD;
                    w_cnt_nx   = c_HOLD_LOAD;
                    w_busy_nx  = 1'b1;
                end
            end
            S_HOLD: begin
                // Requests are deliberately not sampled here so the pattern stays up.
                if (r_cnt == '0) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx   = r_cnt - 1'b1;
                    w_busy_nx  = 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_last  <= c_LAST_RST;
            r_cnt   <= '0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
            r_gid   <= '0;
            r_cs    <= 1'b0;
            r_wn    <= 1'b1;
            r_wd    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_last  <= w_last_nx;
            r_cnt   <= w_cnt_nx;
            r_ack   <= w_ack_nx;
            r_busy  <= w_busy_nx;
            r_gid   <= w_gid_nx;
            r_cs    <= w_cs_nx;
            r_wn    <= w_wn_nx;
            r_wd    <= w_wd_nx;
        end
    end

    assign ack            = r_ack;
    assign busy           = r_busy;
    assign grant_id       = r_gid;
    assign pio_address    = 2'b00;
    assign pio_chipselect = r_cs;
    assign pio_write_n    = r_wn;
    assign pio_writedata  = r_wd;

endmodule
`default_nettype wire

// File: tb/tb_ledg_pio_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ledg_pio_write_arbiter
//  Purpose  : Self-checking bench for ledg_pio_write_arbiter (hold 16 and hold 0).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ledg_pio_write_arbiter;

    localparam int N  = 4;
    localparam int H  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, req_z;
    logic [31:0] rd, rd_z;
    logic [3:0]  ack, ack_z;
    logic        busy, busy_z;
    logic [2:0]  gid, gid_z;
    logic [1:0]  addr, addr_z;
    logic        cs, cs_z, wn, wn_z;
    logic [31:0] wd, wd_z;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct packed {
        int          cnt;
        int          last;
        logic [3:0]  ack;
        logic        busy;
        logic [2:0]  gid;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
    } model_t;

    ledg_pio_write_arbiter #(.NUM_REQ(N), .DATA_W(8), .HOLD_CYCLES(H)) dut (
        .clk(clk), .reset(rst), .req(req), .req_data(rd), .ack(ack), .busy(busy),
        .grant_id(gid), .pio_address(addr), .pio_chipselect(cs),
        .pio_write_n(wn), .pio_writedata(wd)
    );

    ledg_pio_write_arbiter #(.NUM_REQ(N), .DATA_W(8), .HOLD_CYCLES(0)) dut_z (
        .clk(clk), .reset(rst), .req(req_z), .req_data(rd_z), .ack(ack_z), .busy(busy_z),
        .grant_id(gid_z), .pio_address(addr_z), .pio_chipselect(cs_z),
        .pio_write_n(wn_z), .pio_writedata(wd_z)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A grant occupies the write cycle plus h hold cycles; arbitration is
    // possible again only once that budget has run out.
    function automatic model_t model_init();
        model_t m;
        m.cnt = 0; m.last = N - 1; m.ack = '0; m.busy = 1'b0; m.gid = '0;
        m.cs = 1'b0; m.wn = 1'b1; m.wd = '0;
        return m;
    endfunction

    function automatic model_t model_step(model_t m, logic [3:0] r, logic [31:0] d, int h);
        model_t n = m;
        bit     done = 0;
        n.ack = '0; n.cs = 1'b0; n.wn = 1'b1;
        if (m.cnt == 0) begin
            n.busy = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m.last + k) % N;
                if (!done && r[idx]) begin
                    done   = 1;
                    n.last = idx;
                    n.gid  = 3'(idx);
                    n.wd   = {24'b0, d[idx*8 +: 8]};
                    n.ack  = 4'b0001 << idx;
                    n.cs   = 1'b1;
                    n.wn   = 1'b0;
                    n.busy = 1'b1;
                    n.cnt  = h + 1;
                end
            end
        end else begin
            n.cnt  = m.cnt - 1;
            n.busy = (n.cnt != 0);
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; req_z = '0; rd = '0; rd_z = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ack(input int limit, output int id, output bit ok);
        ok = 0; id = -1;
        for (int i = 0; i < limit && !ok; i++) begin
            tick();
            if (ack != 4'b0) begin
                ok = 1;
                for (int j = 0; j < N; j++) if (ack[j]) id = j;
            end
        end
    endtask

    task automatic test_reset();
        req = 4'b1111; rd = 32'h1234_5678; req_z = '0; rd_z = '0;
        rst = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({ack, busy, gid} !== 8'b0) begin
            n_fail++; $display("FAIL reset_ctrl got ack=%b busy=%b gid=%0d expected 0/0/0", ack, busy, gid);
        end
        n_tests++;
        if ({cs, wn, addr} !== 4'b0100) begin
            n_fail++; $display("FAIL reset_bus got cs=%b wn=%b addr=%0d expected cs=0 wn=1 addr=0", cs, wn, addr);
        end
        n_tests++;
        if (wd !== 32'h0) begin
            n_fail++; $display("FAIL reset_wdata got %h expected 00000000", wd);
        end
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        int bad = 0;
        do_reset();
        req = 4'b0100; rd = 32'h00A5_0000;
        tick();
        req = '0;
        n_tests++;
        if ({cs, wn} !== 2'b10 || wd !== 32'h0000_00A5) begin
            n_fail++; $display("FAIL single_write got cs=%b wn=%b wd=%h expected cs=1 wn=0 wd=000000a5", cs, wn, wd);
        end
        n_tests++;
        if (ack !== 4'b0100 || gid !== 3'd2 || busy !== 1'b1) begin
            n_fail++; $display("FAIL single_ack got ack=%b gid=%0d busy=%b expected 0100/2/1", ack, gid, busy);
        end
        for (int i = 0; i < H; i++) begin
            tick();
            if (busy !== 1'b1 || cs !== 1'b0 || wn !== 1'b1 || ack !== 4'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL single_hold got %0d bad hold cycles expected 0", bad);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL single_release got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_all_request();
        int ids[$];
        int times[$];
        logic [31:0] wds[$];
        do_reset();
        req = 4'b1111; rd = 32'h4433_2211;
        for (int i = 0; i < 120 && ids.size() < 4; i++) begin
            tick();
            if (ack != 4'b0) begin
                ids.push_back(int'(gid));
                times.push_back(cyc);
                wds.push_back(wd);
                req = req & ~ack;
            end
        end
        n_tests++;
        if (ids.size() != 4) begin
            n_fail++; $display("FAIL all_req_count got %0d grants expected 4", ids.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_tests++;
                if (ids[k] != k || wds[k] !== 32'(17 * (k + 1))) begin
                    n_fail++; $display("FAIL all_req_order[%0d] got id=%0d wd=%h expected id=%0d wd=%h",
                                       k, ids[k], wds[k], k, 32'(17 * (k + 1)));
                end
                if (k > 0) begin
                    n_tests++;
                    if (times[k] - times[k-1] != H + 2) begin
                        n_fail++; $display("FAIL all_req_spacing[%0d] got %0d expected %0d",
                                           k, times[k] - times[k-1], H + 2);
                    end
                end
            end
        end
        req = '0;
    endtask

    task automatic rr_case(input logic [3:0] second, input int exp_id, input string tag);
        int id; bit ok;
        do_reset();
        rd = 32'hDDCC_BBAA;
        req = 4'b0010;
        wait_ack(40, id, ok);
        req = second;
        n_tests++;
        if (!ok || id != 1) begin
            n_fail++; $display("FAIL %s_first got ok=%0d id=%0d expected id=1", tag, ok, id);
        end
        wait_ack(60, id, ok);
        req = '0;
        n_tests++;
        if (!ok || id != exp_id) begin
            n_fail++; $display("FAIL %s_next got ok=%0d id=%0d expected id=%0d", tag, ok, id, exp_id);
        end
    endtask

    task automatic test_round_robin();
        rr_case(4'b0011, 0, "rr_wrap");
        rr_case(4'b1011, 3, "rr_skip");
    endtask

    task automatic test_hold0();
        int ids[$];
        int times[$];
        do_reset();
        req_z = 4'b0011; rd_z = 32'h0000_7E3C;
        for (int i = 0; i < 30 && ids.size() < 6; i++) begin
            tick();
            if (ack_z != 4'b0) begin
                ids.push_back(int'(gid_z));
                times.push_back(cyc);
            end
        end
        req_z = '0;
        n_tests++;
        if (ids.size() != 6) begin
            n_fail++; $display("FAIL hold0_count got %0d grants expected 6", ids.size());
        end else begin
            for (int k = 1; k < 6; k++) begin
                n_tests++;
                if (ids[k] != (k % 2) || times[k] - times[k-1] != 2) begin
                    n_fail++; $display("FAIL hold0_alt[%0d] got id=%0d gap=%0d expected id=%0d gap=2",
                                       k, ids[k], times[k] - times[k-1], k % 2);
                end
            end
        end
    endtask

    task automatic test_withdrawn();
        int id; bit ok; int seen = 0;
        do_reset();
        rd = 32'h5A00_0011;
        req = 4'b0001;
        wait_ack(40, id, ok);
        req = '0;
        tick(); tick(); tick();
        req = 4'b1000;
        tick();
        req = '0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ack != 4'b0 || cs !== 1'b0) seen++;
        end
        n_tests++;
        if (!ok || seen != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL withdrawn got first_ok=%0d stray_writes=%0d busy=%b expected 1/0/0", ok, seen, busy);
        end
    endtask

    task automatic test_reset_mid();
        int id; bit ok;
        do_reset();
        req = 4'b0100; rd = 32'h0077_0000;
        tick();
        n_tests++;
        if (cs !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre got cs=%b expected 1", cs);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({cs, wn, ack, busy} !== 7'b0100000) begin
            n_fail++; $display("FAIL rstmid_idle got cs=%b wn=%b ack=%b busy=%b expected 0/1/0000/0", cs, wn, ack, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 4'b1001;
        wait_ack(40, id, ok);
        req = '0;
        n_tests++;
        if (!ok || id != 0) begin
            n_fail++; $display("FAIL rstmid_restart got ok=%0d id=%0d expected id=0", ok, id);
        end
    endtask

    task automatic test_random();
        model_t m, mz;
        do_reset();
        m  = model_init();
        mz = model_init();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) req   = 4'($urandom);
            if ($urandom_range(0, 3) == 0) req_z = 4'($urandom);
            rd   = $urandom;
            rd_z = $urandom;
            m  = model_step(m, req, rd, H);
            mz = model_step(mz, req_z, rd_z, 0);
            tick();
            n_tests++;
            if ({ack, busy, gid, cs, wn, addr, wd} !== {m.ack, m.busy, m.gid, m.cs, m.wn, 2'b00, m.wd}) begin
                n_fail++;
                $display("FAIL rand_h16 cyc=%0d got ack=%b busy=%b gid=%0d cs=%b wn=%b wd=%h expected ack=%b busy=%b gid=%0d cs=%b wn=%b wd=%h",
                         cyc, ack, busy, gid, cs, wn, wd, m.ack, m.busy, m.gid, m.cs, m.wn, m.wd);
            end
            n_tests++;
            if ({ack_z, busy_z, gid_z, cs_z, wn_z, addr_z, wd_z} !== {mz.ack, mz.busy, mz.gid, mz.cs, mz.wn, 2'b00, mz.wd}) begin
                n_fail++;
                $display("FAIL rand_h0 cyc=%0d got ack=%b busy=%b gid=%0d cs=%b wn=%b wd=%h expected ack=%b busy=%b gid=%0d cs=%b wn=%b wd=%h",
                         cyc, ack_z, busy_z, gid_z, cs_z, wn_z, wd_z, mz.ack, mz.busy, mz.gid, mz.cs, mz.wn, mz.wd);
            end
        end
        req = '0; req_z = '0;
    endtask

    initial begin
        rst = 1'b1; req = '0; req_z = '0; rd = '0; rd_z = '0;
        test_reset();
        test_single();
        test_all_request();
        test_round_robin();
        test_hold0();
        test_withdrawn();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
